// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package hazard_pkg;

  // Controller states: one flush cycle after reset, normal operation, cache-miss stall
  typedef enum logic [1:0] {
    RST  = 2'd0,
    IDLE = 2'd1,
    MISS = 2'd2
  } hz_state_t;

  // EX operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Hard-wired zero register, never a forwarding source
  localparam logic [4:0] X0 = 5'd0;

  // Youngest writer wins: MEM result beats WB data; x0 is never forwarded
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       wen_mem,
    input logic [4:0] dst_mem,
    input logic       wen_wb,
    input logic [4:0] dst_wb
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (wen_mem && (dst_mem != X0) && (dst_mem == src)) begin
      sel = FWD_MEM;
    end else if (wen_wb && (dst_wb != X0) && (dst_wb == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/miss_stall_fsm.sv
// Reset-flush / cache-miss stall state machine with a sticky miss-timeout watchdog.
// Latency: state flags are registered; the stall itself is released combinationally by the parent.
// Backpressure: stays in MISS while miss is held; the watchdog only flags, it never forces an exit.
module miss_stall_fsm
  import hazard_pkg::*;
#(
  parameter int MISS_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic miss,
  input  logic mem_access,
  output logic in_rst,
  output logic in_miss,
  output logic err_timeout
);

  // Counter saturates at MISS_TIMEOUT-1, which is exactly the trip value
  localparam int            CW      = $clog2(MISS_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(MISS_TIMEOUT - 1);

  hz_state_t     state;
  hz_state_t     state_nxt;
  logic [CW-1:0] miss_cnt;

  // State register; asynchronous reset lands in the post-reset flush state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: single flush cycle, enter MISS on a real memory miss, leave when the line arrives
  always_comb begin
    state_nxt = state;
    unique case (state)
      RST:     state_nxt = IDLE;
      IDLE:    if (miss && mem_access) state_nxt = MISS;
      MISS:    if (!miss) state_nxt = IDLE;
      default: state_nxt = RST;
    endcase
  end

  // State decode for the parent
  always_comb begin
    in_rst  = (state == RST);
    in_miss = (state == MISS);
  end

  // Miss duration counter: counts every cycle spent in MISS, cleared on exit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cnt <= '0;
    end else if (state == MISS && miss) begin
      if (miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + 1'b1;
    end else begin
      miss_cnt <= '0;
    end
  end

  // Sticky watchdog flag; only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_timeout <= 1'b0;
    end else if (state == MISS && miss_cnt == CNT_MAX) begin
      err_timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush vector for F..W and EX operand forwarding selects.
// Latency: all hazard outputs are combinational from inputs and the registered FSM state.
// Backpressure: a data-cache miss holds every stage until miss drops; HAZARD_PERF_EN adds perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MISS_TIMEOUT = 1024,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       reg1_srcD,
  input  logic [4:0]       reg2_srcD,
  input  logic [4:0]       reg1_srcE,
  input  logic [4:0]       reg2_srcE,
  input  logic [4:0]       reg_dstE,
  input  logic [4:0]       reg_dstM,
  input  logic [4:0]       reg_dstW,
  input  logic             reg_write_en_EX,
  input  logic             reg_write_en_MEM,
  input  logic             reg_write_en_WB,
  input  logic             wb_select_EX,
  input  logic             br_EX,
  input  logic             jalr_EX,
  input  logic             jal_ID,
  input  logic             mem_access_MEM,
  input  logic             miss,
  output logic             bubbleF,
  output logic             bubbleD,
  output logic             bubbleE,
  output logic             bubbleM,
  output logic             bubbleW,
  output logic             flushF,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             flushW,
  output logic [1:0]       op1_sel,
  output logic [1:0]       op2_sel,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
`endif
  output logic             err_timeout
);

  // Reject parameter values the watchdog and counters cannot honour
  generate
    if (MISS_TIMEOUT < 2 || CNT_W < 1) begin : g_bad_params
      $error("hazard_ctrl: MISS_TIMEOUT must be >= 2 and CNT_W >= 1");
    end
  endgenerate

  logic in_rst;
  logic in_miss;
  logic stall;
  logic redirect;
  logic load_use;

  miss_stall_fsm #(
    .MISS_TIMEOUT(MISS_TIMEOUT)
  ) u_miss_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .miss        (miss),
    .mem_access  (mem_access_MEM),
    .in_rst      (in_rst),
    .in_miss     (in_miss),
    .err_timeout (err_timeout)
  );

  // Hazard decode: miss stall starts the cycle it is seen and drops the cycle miss clears
  always_comb begin
    stall    = !in_rst && miss && (in_miss || mem_access_MEM);
    redirect = br_EX || jalr_EX;
    load_use = wb_select_EX && reg_write_en_EX && (reg_dstE != X0) &&
               ((reg_dstE == reg1_srcD) || (reg_dstE == reg2_srcD));
  end

  // Priority mux: reset flush > miss stall > branch/jalr > load-use > jal
  always_comb begin
    bubbleF = 1'b0;
    bubbleD = 1'b0;
    bubbleE = 1'b0;
    bubbleM = 1'b0;
    bubbleW = 1'b0;
    flushF  = 1'b0;
    flushD  = 1'b0;
    flushE  = 1'b0;
    flushM  = 1'b0;
    flushW  = 1'b0;
    if (in_rst) begin
      flushF = 1'b1;
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
    end else if (stall) begin
      bubbleF = 1'b1;
      bubbleD = 1'b1;
      bubbleE = 1'b1;
      bubbleM = 1'b1;
      bubbleW = 1'b1;
    end else if (redirect) begin
      // Squashing the consumer in ID makes any load-use stall moot
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (load_use) begin
      bubbleF = 1'b1;
      bubbleD = 1'b1;
      flushE  = 1'b1;
    end else if (jal_ID) begin
      flushD = 1'b1;
    end
  end

  // EX operand forwarding; forced to regfile during the reset flush cycle
  always_comb begin
    op1_sel = FWD_RF;
    op2_sel = FWD_RF;
    if (!in_rst) begin
      op1_sel = fwd_sel(reg1_srcE, reg_write_en_MEM, reg_dstM, reg_write_en_WB, reg_dstW);
      op2_sel = fwd_sel(reg2_srcE, reg_write_en_MEM, reg_dstM, reg_write_en_WB, reg_dstW);
    end
  end

`ifdef HAZARD_PERF_EN
  // Perf counters: stalled cycles and redirect/squash cycles, free-running with wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (bubbleF || bubbleD || bubbleE || bubbleM || bubbleW) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
      if (!in_rst && (flushD || flushE)) begin
        flush_events <= flush_events + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random traffic.
// Latency: expectations are formed each cycle from a behavioural model of the pipeline rules.
// Backpressure: the model tracks miss duration as a plain cycle count and a sticky timeout flag.
module tb_hazard_ctrl;

  localparam int T = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] reg1_srcD, reg2_srcD, reg1_srcE, reg2_srcE;
  logic [4:0] reg_dstE, reg_dstM, reg_dstW;
  logic       reg_write_en_EX, reg_write_en_MEM, reg_write_en_WB;
  logic       wb_select_EX, br_EX, jalr_EX, jal_ID, mem_access_MEM, miss;
  logic       bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
  logic       flushF, flushD, flushE, flushM, flushW;
  logic [1:0] op1_sel, op2_sel;
  logic       err_timeout;

  always #5 clk = ~clk;

  hazard_ctrl #(.MISS_TIMEOUT(T), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .reg1_srcD(reg1_srcD), .reg2_srcD(reg2_srcD),
    .reg1_srcE(reg1_srcE), .reg2_srcE(reg2_srcE),
    .reg_dstE(reg_dstE), .reg_dstM(reg_dstM), .reg_dstW(reg_dstW),
    .reg_write_en_EX(reg_write_en_EX), .reg_write_en_MEM(reg_write_en_MEM),
    .reg_write_en_WB(reg_write_en_WB), .wb_select_EX(wb_select_EX),
    .br_EX(br_EX), .jalr_EX(jalr_EX), .jal_ID(jal_ID),
    .mem_access_MEM(mem_access_MEM), .miss(miss),
    .bubbleF(bubbleF), .bubbleD(bubbleD), .bubbleE(bubbleE),
    .bubbleM(bubbleM), .bubbleW(bubbleW),
    .flushF(flushF), .flushD(flushD), .flushE(flushE),
    .flushM(flushM), .flushW(flushW),
    .op1_sel(op1_sel), .op2_sel(op2_sel),
    .err_timeout(err_timeout)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  bit m_rst;
  bit m_miss;
  int m_cycles;
  bit m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (src == 5'd0) return 2'b00;
    if (reg_write_en_MEM && reg_dstM == src) return 2'b01;
    if (reg_write_en_WB && reg_dstW == src) return 2'b10;
    return 2'b00;
  endfunction

  // Compare all outputs with the model for the current inputs
  task automatic check_now();
    logic [9:0] exp_v;
    logic [9:0] got_v;
    bit lu;
    lu = wb_select_EX && reg_write_en_EX && reg_dstE != 5'd0 &&
         (reg_dstE == reg1_srcD || reg_dstE == reg2_srcD);
    if (m_rst)                                         exp_v = 10'b00000_11111;
    else if (miss && (m_miss || mem_access_MEM))       exp_v = 10'b11111_00000;
    else if (br_EX || jalr_EX)                         exp_v = 10'b00000_01100;
    else if (lu)                                       exp_v = 10'b11000_00100;
    else if (jal_ID)                                   exp_v = 10'b00000_01000;
    else                                               exp_v = 10'b00000_00000;
    got_v = {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
             flushF, flushD, flushE, flushM, flushW};
    check("bubble_flush", 32'(got_v), 32'(exp_v));
    check("op1_sel", 32'(op1_sel), m_rst ? 32'd0 : 32'(ref_fwd(reg1_srcE)));
    check("op2_sel", 32'(op2_sel), m_rst ? 32'd0 : 32'(ref_fwd(reg2_srcE)));
    check("err_timeout", 32'(err_timeout), 32'(m_err));
  endtask

  // Model update at a rising edge
  task automatic advance();
    if (m_rst) begin
      m_rst = 1'b0;
    end else if (!m_miss) begin
      if (miss && mem_access_MEM) begin
        m_miss   = 1'b1;
        m_cycles = 0;
      end
    end else begin
      m_cycles++;
      if (m_cycles == T) m_err = 1'b1;
      if (!miss) begin
        m_miss   = 1'b0;
        m_cycles = 0;
      end
    end
  endtask

  // One cycle: check mid-cycle, then clock the model with the edge
  task automatic step();
    @(negedge clk);
    check_now();
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    m_rst    = 1'b1;
    m_miss   = 1'b0;
    m_cycles = 0;
    m_err    = 1'b0;
    #2;
    check_now();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic clr();
    reg1_srcD = 0; reg2_srcD = 0; reg1_srcE = 0; reg2_srcE = 0;
    reg_dstE = 0; reg_dstM = 0; reg_dstW = 0;
    reg_write_en_EX = 0; reg_write_en_MEM = 0; reg_write_en_WB = 0;
    wb_select_EX = 0; br_EX = 0; jalr_EX = 0; jal_ID = 0;
    mem_access_MEM = 0; miss = 0;
  endtask

  initial begin
    clr();
    rst_n = 1'b1;
    #3;
    do_reset();
    step();                       // flush cycle
    step();                       // idle, nothing
    // load x5 in EX, ID reads rs2=x5
    wb_select_EX = 1; reg_write_en_EX = 1; reg_dstE = 5; reg2_srcD = 5;
    step();
    clr(); step();
    // load to x0 never stalls
    wb_select_EX = 1; reg_write_en_EX = 1; reg_dstE = 0; reg1_srcD = 0;
    step();
    // branch overrides load-use
    reg_dstE = 5; reg1_srcD = 5; br_EX = 1;
    step();
    clr(); jalr_EX = 1; step();
    clr(); jal_ID = 1; step();
    // 5-cycle miss with a branch waiting in EX
    clr(); br_EX = 1; mem_access_MEM = 1; miss = 1;
    repeat (5) step();
    miss = 0; step();
    clr(); step();
    // watchdog: miss held 10 cycles
    mem_access_MEM = 1; miss = 1;
    repeat (10) step();
    clr(); repeat (3) step();
    // forwarding priority
    reg_dstM = 7; reg_dstW = 7; reg_write_en_MEM = 1; reg_write_en_WB = 1; reg1_srcE = 7;
    step();
    reg_write_en_MEM = 0; step();
    reg_dstM = 0; reg_dstW = 0; reg_write_en_MEM = 1; reg1_srcE = 0; step();
    clr(); reg_dstW = 3; reg_write_en_WB = 1; reg2_srcE = 3; step();
    // reset clears the sticky flag
    clr(); do_reset(); step(); step();
    // random traffic, including resets landing mid-miss
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(99) == 0) do_reset();
      reg1_srcD = 5'($urandom_range(3)); reg2_srcD = 5'($urandom_range(3));
      reg1_srcE = 5'($urandom_range(3)); reg2_srcE = 5'($urandom_range(3));
      reg_dstE  = 5'($urandom_range(3)); reg_dstM  = 5'($urandom_range(3));
      reg_dstW  = 5'($urandom_range(3));
      reg_write_en_EX  = 1'($urandom_range(1));
      reg_write_en_MEM = 1'($urandom_range(1));
      reg_write_en_WB  = 1'($urandom_range(1));
      wb_select_EX     = 1'($urandom_range(1));
      br_EX   = ($urandom_range(7) == 0);
      jalr_EX = ($urandom_range(11) == 0);
      jal_ID  = ($urandom_range(5) == 0);
      mem_access_MEM = 1'($urandom_range(1));
      miss = m_miss ? ($urandom_range(9) != 0) : ($urandom_range(7) == 0);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
